// File: rtl/xor_pkg.sv
// -----------------------------------------------------------------------------
// xor_pkg
// Shared definitions for the XOR gate family: the checksum FSM state type and
// the default data width / frame length used by the gate-family blocks.
// No ports (package).
// -----------------------------------------------------------------------------
package xor_pkg;

    localparam int XOR_DATA_W_DEF  = 8;
    localparam int XOR_MAX_LEN_DEF = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } xcs_state_e;

endpackage : xor_pkg

// File: rtl/xor_reduce.sv
// -----------------------------------------------------------------------------
// xor_reduce
// Parametrised XOR tree producing the parity (XOR-reduce) of a DATA_W-bit word.
// Reusable by parity blocks and the gate benches.
//
// Ports:
//   i_data   [DATA_W-1:0]  word to reduce
//   o_parity               XOR of all bits of i_data
// -----------------------------------------------------------------------------
module xor_reduce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);

    // Pad to a power of two so every level folds cleanly in half.
    localparam int LEVELS = $clog2(DATA_W);
    localparam int LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0] w_fold;

    // Fold the upper half onto the lower half each level: log2 depth tree.
    always_comb begin
        w_fold = LEAVES'(i_data);
        for (int s = LEAVES / 2; s >= 1; s = s / 2) begin
            for (int k = 0; k < s; k++) begin
                w_fold[k] = w_fold[k] ^ w_fold[k + s];
            end
        end
    end

    assign o_parity = w_fold[0];

endmodule : xor_reduce

// File: rtl/xor_checksum_unit.sv
// -----------------------------------------------------------------------------
// xor_checksum_unit
// Streaming XOR checksum. Accumulates the bitwise XOR of every accepted word in
// a frame and, on the frame's last beat, presents checksum, parity, saturating
// beat count and overflow flag on a valid/ready result channel.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mode_odd                    parity mode (1 = odd), latched on first beat
//   in_valid/in_ready           input handshake
//   in_data [DATA_W-1:0]        input word
//   in_last                     final beat of frame
//   out_valid/out_ready         result handshake
//   out_checksum [DATA_W-1:0]   XOR of all frame words
//   out_parity                  XOR-reduce of checksum ^ latched mode
//   out_count [CNT_W-1:0]       beats in frame, saturating at MAX_LEN
//   out_overflow                frame exceeded MAX_LEN beats
// -----------------------------------------------------------------------------
module xor_checksum_unit
    import xor_pkg::*;
#(
    parameter int DATA_W  = XOR_DATA_W_DEF,
    parameter int MAX_LEN = XOR_MAX_LEN_DEF,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_odd,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_checksum,
    output logic              out_parity,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    xcs_state_e        r_state;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_mode;

    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_checksum;
    logic              r_out_parity;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_overflow;

    logic [DATA_W-1:0] w_acc_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_ovf_next;
    logic              w_mode_next;
    logic              w_reduce;
    logic              w_parity_next;

    // Counter stops at MAX_LEN instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    // Next-state values for an accepted beat in ST_ACCUM.
    assign w_acc_next  = r_acc ^ in_data;
    assign w_cnt_next  = sat_inc(r_cnt);
    assign w_ovf_next  = r_ovf | (r_cnt == CNT_MAX);
    // A zero count can only mean the first beat, since the counter never wraps.
    assign w_mode_next = (r_cnt == '0) ? mode_odd : r_mode;

    xor_reduce #(
        .DATA_W (DATA_W)
    ) u_xor_reduce (
        .i_data   (w_acc_next),
        .o_parity (w_reduce)
    );

    assign w_parity_next = w_reduce ^ w_mode_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_ACCUM;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_mode         <= 1'b0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_checksum <= '0;
            r_out_parity   <= 1'b0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc  <= w_acc_next;
                        r_cnt  <= w_cnt_next;
                        r_ovf  <= w_ovf_next;
                        r_mode <= w_mode_next;
                        if (in_last) begin
                            r_out_checksum <= w_acc_next;
                            r_out_parity   <= w_parity_next;
                            r_out_count    <= w_cnt_next;
                            r_out_overflow <= w_ovf_next;
                            r_out_valid    <= 1'b1;
                            r_in_ready     <= 1'b0;
                            r_state        <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result outputs keep their values; only valid drops.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_checksum = r_out_checksum;
    assign out_parity   = r_out_parity;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;

endmodule : xor_checksum_unit

// File: tb/tb_xor_checksum_unit.sv
// -----------------------------------------------------------------------------
// tb_xor_checksum_unit
// Two instances share one stimulus stream: MAX_LEN=16 (A) and MAX_LEN=4 (B).
// A frame-level reference model turns each completed frame into its expected
// result; results are compared every cycle they are presented.
// -----------------------------------------------------------------------------
module tb_xor_checksum_unit;

    localparam int DW   = 8;
    localparam int ML_A = 16;
    localparam int ML_B = 4;
    localparam int CW_A = $clog2(ML_A + 1);
    localparam int CW_B = $clog2(ML_B + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       = 1'b1;
    logic          mode_odd  = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b1;

    logic            in_ready_a, out_valid_a, out_parity_a, out_overflow_a;
    logic [DW-1:0]   out_checksum_a;
    logic [CW_A-1:0] out_count_a;
    logic            in_ready_b, out_valid_b, out_parity_b, out_overflow_b;
    logic [DW-1:0]   out_checksum_b;
    logic [CW_B-1:0] out_count_b;

    xor_checksum_unit #(.DATA_W(DW), .MAX_LEN(ML_A)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .mode_odd     (mode_odd),
        .in_valid     (in_valid),
        .in_ready     (in_ready_a),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_checksum (out_checksum_a),
        .out_parity   (out_parity_a),
        .out_count    (out_count_a),
        .out_overflow (out_overflow_a)
    );

    xor_checksum_unit #(.DATA_W(DW), .MAX_LEN(ML_B)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .mode_odd     (mode_odd),
        .in_valid     (in_valid),
        .in_ready     (in_ready_b),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready),
        .out_checksum (out_checksum_b),
        .out_parity   (out_parity_b),
        .out_count    (out_count_b),
        .out_overflow (out_overflow_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] cs;
        logic          par;
        int            cnt_a;
        logic          ovf_a;
        int            cnt_b;
        logic          ovf_b;
    } res_t;

    res_t          expq[$];
    logic [DW-1:0] cur[$];
    logic          cur_mode  = 1'b0;
    int            frames_in = 0;
    int            frames_out = 0;
    bit            mon_on    = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            // A result is presented exactly while the model holds one.
            check_eq("out_valid_a", out_valid_a, expq.size() != 0);
            check_eq("in_ready_a",  in_ready_a,  expq.size() == 0);
            check_eq("out_valid_b", out_valid_b, expq.size() != 0);
            check_eq("in_ready_b",  in_ready_b,  expq.size() == 0);
            if (expq.size() != 0 && out_valid_a === 1'b1) begin
                check_eq("cs_a",  out_checksum_a, expq[0].cs);
                check_eq("par_a", out_parity_a,   expq[0].par);
                check_eq("cnt_a", out_count_a,    expq[0].cnt_a);
                check_eq("ovf_a", out_overflow_a, expq[0].ovf_a);
                check_eq("cs_b",  out_checksum_b, expq[0].cs);
                check_eq("par_b", out_parity_b,   expq[0].par);
                check_eq("cnt_b", out_count_b,    expq[0].cnt_b);
                check_eq("ovf_b", out_overflow_b, expq[0].ovf_b);
            end
            // Predict what the coming rising edge does.
            if (rst) begin
                frames_in -= expq.size();
                expq.delete();
                cur.delete();
            end else begin
                if (expq.size() != 0 && out_ready) begin
                    void'(expq.pop_front());
                    frames_out++;
                end else if (expq.size() == 0 && in_valid) begin
                    if (cur.size() == 0) cur_mode = mode_odd;
                    cur.push_back(in_data);
                    if (in_last) begin
                        res_t r;
                        int   n;
                        n    = cur.size();
                        r.cs = '0;
                        foreach (cur[i]) r.cs = r.cs ^ cur[i];
                        r.par   = (($countones(r.cs) % 2) == 1) ^ cur_mode;
                        r.cnt_a = (n > ML_A) ? ML_A : n;
                        r.ovf_a = (n > ML_A);
                        r.cnt_b = (n > ML_B) ? ML_B : n;
                        r.ovf_b = (n > ML_B);
                        expq.push_back(r);
                        frames_in++;
                        cur.delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic m);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode_odd = m;
        while (in_ready_a !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check_eq("send_timeout", guard, 0);
        tick();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_last  = 1'($urandom);
        mode_odd = 1'($urandom);
    endtask

    bit rand_on = 1'b0;

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        check_eq("rst_valid",   out_valid_a,    1'b0);
        check_eq("rst_ready",   in_ready_a,     1'b1);
        check_eq("rst_cs",      out_checksum_a, '0);
        check_eq("rst_par",     out_parity_a,   1'b0);
        check_eq("rst_cnt",     out_count_a,    '0);
        check_eq("rst_ovf",     out_overflow_a, 1'b0);
        rst = 1'b0;
        tick();

        // Even-mode three-beat frame
        out_ready = 1'b1;
        send(8'h0F, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        check_eq("t1_valid", out_valid_a,    1'b1);
        check_eq("t1_cs",    out_checksum_a, 8'h55);
        check_eq("t1_par",   out_parity_a,   1'b0);
        check_eq("t1_cnt",   out_count_a,    3);
        check_eq("t1_ovf",   out_overflow_a, 1'b0);
        tick();
        check_eq("t1_done",  out_valid_a,    1'b0);

        // Odd mode latched on first beat, toggled later
        send(8'h0F, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        check_eq("t2_cs",  out_checksum_a, 8'h55);
        check_eq("t2_par", out_parity_a,   1'b1);
        tick();

        // Single beat held under back-pressure
        out_ready = 1'b0;
        send(8'h81, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_valid", out_valid_a,    1'b1);
            check_eq("t3_ready", in_ready_a,     1'b0);
            check_eq("t3_cs",    out_checksum_a, 8'h81);
            check_eq("t3_cnt",   out_count_a,    1);
            check_eq("t3_par",   out_parity_a,   1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("t3_valid_off", out_valid_a, 1'b0);
        check_eq("t3_ready_on",  in_ready_a,  1'b1);

        // Overflow past MAX_LEN=4 (instance B), then a clean frame
        for (int i = 0; i < 6; i++) send(8'(1 << i), 1'(i == 5), 1'b0);
        check_eq("t4_cs_b",  out_checksum_b, 8'h3F);
        check_eq("t4_par_b", out_parity_b,   1'b0);
        check_eq("t4_cnt_b", out_count_b,    4);
        check_eq("t4_ovf_b", out_overflow_b, 1'b1);
        check_eq("t4_cnt_a", out_count_a,    6);
        check_eq("t4_ovf_a", out_overflow_a, 1'b0);
        tick();
        send(8'hFF, 1'b1, 1'b0);
        check_eq("t4b_cnt_b", out_count_b,    1);
        check_eq("t4b_ovf_b", out_overflow_b, 1'b0);
        check_eq("t4b_par_b", out_parity_b,   1'b0);
        tick();

        // Reset mid-frame discards the partial frame
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_valid", out_valid_a, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        check_eq("t5_cs",  out_checksum_a, 8'h33);
        check_eq("t5_cnt", out_count_a,    1);
        tick();

        // Reset while holding a result discards it
        out_ready = 1'b0;
        send(8'h5A, 1'b1, 1'b1);
        check_eq("t6_valid", out_valid_a, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_valid_off", out_valid_a, 1'b0);
        check_eq("t6_ready_on",  in_ready_a,  1'b1);
        out_ready = 1'b1;
        tick();

        // Random back-to-back frames with random gaps and back-pressure
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 150; f++) begin
                    int len;
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) begin
                        int gap;
                        gap = $urandom_range(0, 2);
                        for (int g = 0; g < gap; g++) tick();
                        send(DW'($urandom), 1'(b == len - 1), 1'($urandom));
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    tick();
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;

        begin
            int guard;
            guard = 0;
            while (expq.size() != 0 && guard < 50) begin
                tick();
                guard++;
            end
        end
        tick();
        check_eq("drain",       expq.size(), 0);
        check_eq("frame_count", frames_out, frames_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_xor_checksum_unit

// File: doc/xor_checksum_unit.md
Name: xor_checksum_unit

Overview:
- Streaming successor to the two-input XOR gate, parametrised in data width.
- Accepts a frame of DATA_W-bit words over a valid/ready input channel and accumulates their running bitwise XOR as a checksum.
- On the frame's last beat it presents the checksum, a single parity bit (even or odd mode), a beat count and an overflow flag on a valid/ready output channel.
- Sits between a data source and a link/packet framer that appends check bits.

Parameters:
- DATA_W, 8, width of input words and checksum (>=1).
- MAX_LEN, 16, frame beat count at which out_count saturates (>=1).
- CNT_W, $clog2(MAX_LEN+1), width of out_count (derived, not overridden).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- mode_odd  input  1  parity mode: 0 = even, 1 = odd; sampled on the first accepted beat of a frame.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat.
- in_data  input  DATA_W  input word.
- in_last  input  1  marks the final beat of a frame.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_checksum  output  DATA_W  XOR of all words in the frame.
- out_parity  output  1  XOR-reduce of out_checksum, XORed with the frame's latched mode_odd.
- out_count  output  CNT_W  beats in the frame, saturating at MAX_LEN.
- out_overflow  output  1  frame exceeded MAX_LEN beats.

Behaviour:
- Reset (rst=1 at a clk edge): state=ST_ACCUM, accumulator=0, beat counter=0, overflow=0, latched mode=0.
- Reset values of outputs: out_valid=0, out_checksum=0, out_parity=0, out_count=0, out_overflow=0, in_ready=1 (first cycle after reset).
- Reset mid-frame or while holding a result discards everything; no partial result is ever emitted.
- FSM, state ST_ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid && in_ready: acc <= acc ^ in_data; cnt <= (cnt==MAX_LEN) ? MAX_LEN : cnt+1.
  - If cnt==MAX_LEN when a beat is accepted, overflow <= 1. Overflow is sticky for the rest of the frame.
  - On the first beat of a frame (cnt==0), latch mode_odd.
  - Accepted beat with in_last=1: register out_checksum = acc^in_data, out_count = the updated cnt, out_overflow = the updated overflow, and out_parity; go to ST_HOLD.
- FSM, state ST_HOLD:
  - in_ready=0, out_valid=1.
  - All outputs are stable while out_ready=0.
  - On out_ready=1: out_valid falls next cycle; acc, cnt, overflow clear; go to ST_ACCUM.
  - No beat is accepted in the handoff cycle. in_ready returns 1 on the cycle after the result handshake.
- Latency: result valid 1 cycle after the in_last beat is accepted. Throughput is one beat per cycle within a frame, plus a minimum one-cycle bubble per frame.
- A single-beat frame (in_last on the first beat) gives checksum = in_data and count = 1.
- in_last without in_valid is ignored.
- in_data, in_last and mode_odd are don't-care when not accepted.
- in_ready depends only on state, never combinationally on in_valid. out_valid likewise does not depend on out_ready.
- Accumulator uses no arithmetic, XOR only. Counter arithmetic is unsigned CNT_W, with no wrap.

Decomposition:
- Shared package xor_pkg:
  - state typedef (ST_ACCUM, ST_HOLD).
  - default DATA_W/MAX_LEN constants, shared with the other gate-family blocks.
- One sub-module: xor_reduce, a parametrised DATA_W-input XOR tree that produces the parity bit. It is reusable by future parity blocks and by the existing gate benches.

Test Plan:
- Even mode, frame 0x0F, 0xF0, 0xAA (last), out_ready=1 -> one cycle later out_valid=1, out_checksum=0x55, out_parity=0, out_count=3, out_overflow=0.
- Same frame with mode_odd=1 on the first beat, then mode_odd toggled mid-frame -> out_checksum=0x55, out_parity=1 (mode latched at the first beat).
- Single beat 0x81 with in_last, out_ready held 0 for 5 cycles -> out_valid=1, checksum 0x81, parity 0, count 1, all outputs stable and in_ready=0 throughout. out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- MAX_LEN=4, six beats 0x01, 0x02, 0x04, 0x08, 0x10, 0x20 (last) -> checksum 0x3F, parity 0, out_count=4, out_overflow=1. The next frame 0xFF (last) -> count 1, overflow 0.
- rst pulsed after 2 beats of a frame, then frame 0x33 (last) -> no result emitted for the aborted frame; result is checksum 0x33, count 1.
- Back-to-back random frames (lengths 1–20, random in_valid/out_ready) checked against a scoreboard model -> every field matches, no beat dropped or duplicated.
